dram_bridge: RTL

Bridges the core's 32-bit word DRAM request port to a 16-bit, pipelined command/response memory port such as an SDRAM controller front end. Sits directly downstream of `core`: it consumes `dram_addr`, `dram_data_out`, `dram_req_read` and `dram_req_write`, and produces `dram_data_in`, `dram_data_valid` and `dram_write_complete`. Each word access is split into two halfword commands. A watchdog guarantees that the core is always answered.

---
 rtl/dram_bridge_pkg.sv | 19 +
 rtl/dram_bridge_if.sv | 22 ++
 rtl/dram_bridge.sv | 134 +++++++++++++
 3 files changed

// File: rtl/dram_bridge_pkg.sv
// Shared types and constants for the 32-bit word to 16-bit halfword DRAM bridge.
package dram_bridge_pkg;

    typedef enum logic [2:0] {
        IDLE,
        CMD_LO,
        CMD_HI,
        WAIT_RD,
        RESP,
        DONE
    } state_t;

    // Operation encoding doubles as the memory write-enable.
    localparam logic OP_READ  = 1'b0;
    localparam logic OP_WRITE = 1'b1;

    localparam logic [31:0] TIMEOUT_DATA = 32'hDEADBEEF;

endpackage

// File: rtl/dram_bridge_if.sv
// Pipelined 16-bit command/response memory port; the bridge is the master.
interface dram_bridge_if #(
    parameter int ADDR_W = 24
);
    logic [ADDR_W:0] mem_addr;
    logic [15:0]     mem_wdata;
    logic            mem_we;
    logic            mem_cmd_valid;
    logic            mem_cmd_ready;
    logic [15:0]     mem_rdata;
    logic            mem_rdata_valid;

    modport master (
        output mem_addr, mem_wdata, mem_we, mem_cmd_valid,
        input  mem_cmd_ready, mem_rdata, mem_rdata_valid
    );

    modport slave (
        input  mem_addr, mem_wdata, mem_we, mem_cmd_valid,
        output mem_cmd_ready, mem_rdata, mem_rdata_valid
    );
endinterface

// File: rtl/dram_bridge.sv
// Splits each 32-bit core word access into two halfword memory commands and
// reassembles read returns; a watchdog forces completion if memory stalls.
module dram_bridge
    import dram_bridge_pkg::*;
#(
    parameter int ADDR_W  = 24,
    parameter int TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] dram_addr,
    input  logic [31:0]       dram_data_out,
    input  logic              dram_req_read,
    input  logic              dram_req_write,
    output logic [31:0]       dram_data_in,
    output logic              dram_data_valid,
    output logic              dram_write_complete,
    output logic              err,
    dram_bridge_if.master     mem
);

    localparam logic [15:0] WD_LAST = 16'(TIMEOUT - 1);

    state_t      state;
    logic        op;
    logic [15:0] wdata_hi;
    logic [1:0]  rcnt;
    logic [15:0] wd;

    logic accept;
    logic timed;
    logic timeout;
    logic capture;

    assign accept  = mem.mem_cmd_valid && mem.mem_cmd_ready;
    assign timed   = state inside {CMD_LO, CMD_HI, WAIT_RD};
    // The watchdog fires on the edge where the count reaches TIMEOUT.
    assign timeout = timed && (wd == WD_LAST);
    assign capture = (state == CMD_HI || state == WAIT_RD) && (op == OP_READ)
                     && mem.mem_rdata_valid && (rcnt != 2'd2);

    assign mem.mem_we = op;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state               <= IDLE;
            op                  <= OP_READ;
            wdata_hi            <= '0;
            rcnt                <= '0;
            wd                  <= '0;
            mem.mem_addr        <= '0;
            mem.mem_wdata       <= '0;
            mem.mem_cmd_valid   <= 1'b0;
            dram_data_in        <= '0;
            dram_data_valid     <= 1'b0;
            dram_write_complete <= 1'b0;
            err                 <= 1'b0;
        end else begin
            // NOTE: non-blocking throughout, so later assignments in this block
            // override earlier ones without creating ordering hazards.
            dram_data_valid     <= 1'b0;
            dram_write_complete <= 1'b0;

            if (timed) begin
                wd <= wd + 16'd1;
            end

            if (capture) begin
                if (rcnt[0]) begin
                    dram_data_in[31:16] <= mem.mem_rdata;
                end else begin
                    dram_data_in[15:0]  <= mem.mem_rdata;
                end
                rcnt <= rcnt + 2'd1;
            end

            if (timeout) begin
                state             <= RESP;
                err               <= 1'b1;
                mem.mem_cmd_valid <= 1'b0;
                if (op == OP_READ) begin
                    dram_data_in    <= TIMEOUT_DATA;
                    dram_data_valid <= 1'b1;
                end else begin
                    dram_write_complete <= 1'b1;
                end
            end else begin
                case (state)
                    IDLE: begin
                        if (dram_req_read || dram_req_write) begin
                            op                <= dram_req_read ? OP_READ : OP_WRITE;
                            mem.mem_addr      <= {dram_addr, 1'b0};
                            mem.mem_wdata     <= dram_data_out[15:0];
                            wdata_hi          <= dram_data_out[31:16];
                            mem.mem_cmd_valid <= 1'b1;
                            wd                <= '0;
                            rcnt              <= '0;
                            state             <= CMD_LO;
                        end
                    end
                    CMD_LO: begin
                        if (accept) begin
                            mem.mem_addr[0] <= 1'b1;
                            mem.mem_wdata   <= wdata_hi;
                            state           <= CMD_HI;
                        end
                    end
                    CMD_HI: begin
                        if (accept) begin
                            mem.mem_cmd_valid <= 1'b0;
                            if (op == OP_WRITE) begin
                                dram_write_complete <= 1'b1;
                                state               <= RESP;
                            end else begin
                                state <= WAIT_RD;
                            end
                        end
                    end
                    WAIT_RD: begin
                        if (rcnt == 2'd2) begin
                            dram_data_valid <= 1'b1;
                            state           <= RESP;
                        end
                    end
                    RESP:    state <= DONE;
                    // Requests are not sampled here so the core can drop its level.
                    DONE:    state <= IDLE;
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule
